// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-requester main-memory line arbiter.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  localparam int NUM_BANKS = 4;
  localparam int BEATS     = 4;

  // Requester identities as stored in the owner register.
  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_rd_track_pipe.sv
// Tracks outstanding read beats: shift register of {valid, beat}, RD_LAT deep.
// Latency: an entry pushed in cycle c is presented at the output in cycle c+RD_LAT.
// Backpressure: none; one push per cycle at most, the pipe always advances.
module rd_track_pipe #(
  parameter int RD_LAT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [1:0] push_beat,
  output logic       out_vld,
  output logic [1:0] out_beat,
  output logic       empty
);

  logic [RD_LAT-1:0] vld;
  logic [1:0]        bt [RD_LAT];

  // Advance every stage each cycle; stage 0 takes the newly issued beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        bt[i] <= 2'd0;
      end
    end else begin
      vld[0] <= push;
      bt[0]  <= push_beat;
      for (int i = 1; i < RD_LAT; i++) begin
        vld[i] <= vld[i-1];
        bt[i]  <= bt[i-1];
      end
    end
  end

  assign out_vld  = vld[RD_LAT-1];
  assign out_beat = bt[RD_LAT-1];
  assign empty    = ~|vld;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the four-bank main memory between I-cache (0) and D-cache (1) per 4-beat line.
// Latency: grant one cycle after a request is seen in IDLE; beats then issue one per free-bank cycle.
// Backpressure: a beat whose bank reports mem_busy is held with no strobe until the bank frees.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int RD_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 wr0,
  input  logic                 wr1,
  input  logic [12:0]          addr0,
  input  logic [12:0]          addr1,
  input  logic [DATA_W-1:0]    wdata0,
  input  logic [DATA_W-1:0]    wdata1,
  output logic                 grant0,
  output logic                 grant1,
  output logic [1:0]           beat,
  output logic                 rvalid0,
  output logic                 rvalid1,
  output logic [1:0]           rbeat,
  output logic [DATA_W-1:0]    rdata,
  output logic                 done0,
  output logic                 done1,
  output logic                 err0,
  output logic                 err1,
  output logic [15:0]          mem_addr,
  output logic                 mem_wr,
  output logic                 mem_rd,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic [DATA_W-1:0]    mem_rdata,
  input  logic [NUM_BANKS-1:0] mem_busy,
  input  logic                 mem_err
);

  arb_state_t        state, state_nxt;
  logic              owner;
  logic              own_wr;
  logic              rr_ptr;
  logic              err_flag;
  logic [12:0]       line_addr;
  logic [1:0]        beat_q;

  logic              grant_take;
  logic              grant_id;
  logic              issue;

  logic              pipe_out_vld;
  logic [1:0]        pipe_out_beat;
  logic              pipe_empty;

  logic              rvalid_q;
  logic [1:0]        rbeat_q;
  logic [DATA_W-1:0] rdata_q;

  // Next-state logic, arbitration choice and beat issue decision.
  always_comb begin
    state_nxt  = state;
    grant_take = 1'b0;
    grant_id   = rr_ptr;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        if (req0 && req1) begin
          grant_take = 1'b1;
          grant_id   = rr_ptr;
        end else if (req0) begin
          grant_take = 1'b1;
          grant_id   = REQ_I;
        end else if (req1) begin
          grant_take = 1'b1;
          grant_id   = REQ_D;
        end
        if (grant_take) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        // The target bank of a beat is the beat index itself.
        if (!mem_busy[beat_q]) begin
          issue = 1'b1;
          if (beat_q == 2'(BEATS - 1)) begin
            state_nxt = own_wr ? DONE : DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pipe_empty) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register plus per-transaction context latched at grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= REQ_I;
      own_wr    <= 1'b0;
      rr_ptr    <= REQ_I;
      err_flag  <= 1'b0;
      line_addr <= 13'd0;
      beat_q    <= 2'd0;
    end else begin
      state <= state_nxt;
      if (grant_take) begin
        owner     <= grant_id;
        own_wr    <= (grant_id == REQ_D) ? wr1 : wr0;
        line_addr <= (grant_id == REQ_D) ? addr1 : addr0;
        beat_q    <= 2'd0;
        err_flag  <= 1'b0;
        // Round-robin only moves when both sides competed.
        if (req0 && req1) begin
          rr_ptr <= ~grant_id;
        end
      end else begin
        if (issue) begin
          beat_q <= beat_q + 2'd1;
        end
        // Errors accumulate but never cut the transaction short.
        if (mem_err && ((state == ISSUE) || (state == DRAIN))) begin
          err_flag <= 1'b1;
        end
      end
    end
  end

  rd_track_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_track_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (mem_rd),
    .push_beat (beat_q),
    .out_vld   (pipe_out_vld),
    .out_beat  (pipe_out_beat),
    .empty     (pipe_empty)
  );

  // Capture memory read data as its tracking entry leaves the pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rbeat_q  <= 2'd0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= pipe_out_vld;
      if (pipe_out_vld) begin
        rdata_q <= mem_rdata;
        rbeat_q <= pipe_out_beat;
      end
    end
  end

  assign mem_rd    = issue && !own_wr;
  assign mem_wr    = issue && own_wr;
  assign mem_addr  = {line_addr, beat_q, 1'b0};
  assign mem_wdata = mem_wr ? ((owner == REQ_D) ? wdata1 : wdata0) : '0;
  assign beat      = beat_q;

  assign grant0  = (state != IDLE) && (owner == REQ_I);
  assign grant1  = (state != IDLE) && (owner == REQ_D);
  assign done0   = (state == DONE) && (owner == REQ_I);
  assign done1   = (state == DONE) && (owner == REQ_D);
  assign err0    = done0 && err_flag;
  assign err1    = done1 && err_flag;
  assign rvalid0 = rvalid_q && (owner == REQ_I);
  assign rvalid1 = rvalid_q && (owner == REQ_D);
  assign rbeat   = rbeat_q;
  assign rdata   = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: scoreboarded strobes, read returns and completions.
// Latency: expectations are cycle-exact relative to the cycle a request is first seen.
// Backpressure: bank busy is driven per scenario; the memory model answers RD_LAT cycles after a read.
module tb_mem_port_arbiter;

  localparam int DATA_W = 16;
  localparam int RD_LAT = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req0, req1, wr0, wr1;
  logic [12:0]       addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              grant0, grant1;
  logic [1:0]        beat;
  logic              rvalid0, rvalid1;
  logic [1:0]        rbeat;
  logic [DATA_W-1:0] rdata;
  logic              done0, done1, err0, err1;
  logic [15:0]       mem_addr;
  logic              mem_wr, mem_rd;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = 16'hDEAD;
  logic [3:0]        mem_busy;
  logic              mem_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct { int cyc; logic wr; logic [15:0] addr; logic [15:0] wdata; } strobe_t;
  typedef struct { int cyc; logic id; logic [1:0] rbeat; logic [15:0] rdata; } rv_t;
  typedef struct { int cyc; logic id; logic err; } done_t;

  strobe_t strobe_q[$];
  rv_t     rv_q[$];
  done_t   done_q[$];

  logic [61:0] outs;
  assign outs = {grant0, grant1, beat, rvalid0, rvalid1, rbeat, rdata, done0, done1,
                 err0, err1, mem_addr, mem_wr, mem_rd, mem_wdata};

  // Each cache presents the word for whatever beat the arbiter shows.
  assign wdata0 = 16'h5000 | {14'd0, beat};
  assign wdata1 = 16'h6000 | {14'd0, beat};

  mem_port_arbiter #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .grant0(grant0), .grant1(grant1), .beat(beat),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rbeat(rbeat), .rdata(rdata),
    .done0(done0), .done1(done1), .err0(err0), .err1(err1),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_busy(mem_busy), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] mem_val(input logic [14:0] word);
    return 16'h00A0 + {1'b0, word};
  endfunction

  // Memory model: data for a read issued in cycle c is presented during cycle c+2 (RD_LAT = 2).
  logic [16:0] h0 = '0, h1 = '0, h2 = '0;
  always @(negedge clk) begin
    h2 = h1;
    h1 = h0;
    h0 = {mem_rd, mem_addr};
    mem_rdata = h2[16] ? mem_val(h2[15:1]) : 16'hDEAD;
  end

  // Scoreboard consumer: every DUT event is matched against the oldest expectation of its kind.
  strobe_t se;
  rv_t     re;
  done_t   de;
  always @(negedge clk) begin
    if (mem_wr && mem_rd) begin
      checks = checks + 1; errors = errors + 1;
      $display("FAIL strobe_exclusive cycle=%0d mem_wr=1 mem_rd=1 required at most one", cyc);
    end
    if (grant0 && grant1) begin
      checks = checks + 1; errors = errors + 1;
      $display("FAIL grant_onehot cycle=%0d grant0=1 grant1=1 required at most one", cyc);
    end
    if (mem_wr || mem_rd) begin
      checks = checks + 1;
      if (strobe_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL strobe_unexpected cycle=%0d addr=%h wr=%0b required none", cyc, mem_addr, mem_wr);
      end else begin
        se = strobe_q.pop_front();
        if (se.cyc !== cyc || se.addr !== mem_addr || se.wr !== mem_wr ||
            (se.wr && se.wdata !== mem_wdata)) begin
          errors = errors + 1;
          $display("FAIL strobe got cyc=%0d addr=%h wr=%0b wdata=%h required cyc=%0d addr=%h wr=%0b wdata=%h",
                   cyc, mem_addr, mem_wr, mem_wdata, se.cyc, se.addr, se.wr, se.wdata);
        end
      end
    end
    if (rvalid0 || rvalid1) begin
      checks = checks + 1;
      if (rv_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL rvalid_unexpected cycle=%0d rbeat=%0d rdata=%h required none", cyc, rbeat, rdata);
      end else begin
        re = rv_q.pop_front();
        if (re.cyc !== cyc || re.id !== rvalid1 || (rvalid0 && rvalid1) ||
            re.rbeat !== rbeat || re.rdata !== rdata) begin
          errors = errors + 1;
          $display("FAIL rvalid got cyc=%0d rv0=%0b rv1=%0b rbeat=%0d rdata=%h required cyc=%0d id=%0d rbeat=%0d rdata=%h",
                   cyc, rvalid0, rvalid1, rbeat, rdata, re.cyc, re.id, re.rbeat, re.rdata);
        end
      end
    end
    if (done0 || done1) begin
      checks = checks + 1;
      if (done_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL done_unexpected cycle=%0d done0=%0b done1=%0b required none", cyc, done0, done1);
      end else begin
        de = done_q.pop_front();
        if (de.cyc !== cyc || de.id !== done1 || (done0 && done1) ||
            de.err !== (err0 | err1) || (err0 && !done0) || (err1 && !done1)) begin
          errors = errors + 1;
          $display("FAIL done got cyc=%0d done0=%0b done1=%0b err0=%0b err1=%0b required cyc=%0d id=%0d err=%0b",
                   cyc, done0, done1, err0, err1, de.cyc, de.id, de.err);
        end
      end
    end
  end

  // Expected events for one line transaction whose request is seen in cycle t0.
  // Beats at or after hold_beat are delayed by hold_n busy cycles.
  function automatic void push_txn(input logic id, input logic wr, input logic [12:0] line,
                                   input int t0, input int hold_beat, input int hold_n,
                                   input logic err);
    int ic;
    int last;
    last = t0;
    for (int n = 0; n < 4; n++) begin
      ic = t0 + 1 + n + ((n >= hold_beat) ? hold_n : 0);
      strobe_q.push_back('{ic, wr, {line, 2'(n), 1'b0}, (id ? 16'h6000 : 16'h5000) | 16'(n)});
      if (!wr) rv_q.push_back('{ic + RD_LAT + 1, id, 2'(n), mem_val({line, 2'(n)})});
      last = ic;
    end
    done_q.push_back('{wr ? last + 1 : last + RD_LAT + 2, id, err});
  endfunction

  // Runs the cycle loop for the scenario: busy/error/scramble/drop stimulus relative to t0,
  // releases each request when its done is seen, and stops once everything completed.
  task automatic run_txns(input int t0, input int busy_at, input int busy_len,
                          input logic [3:0] busy_mask, input int err_at,
                          input bit scramble, input int drop_at,
                          output int first_g0, output int first_g1, output bit timed_out);
    int c;
    first_g0  = -1;
    first_g1  = -1;
    timed_out = 1'b1;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk); #1;
      c = cyc - t0;
      mem_busy = (c >= busy_at && c < busy_at + busy_len) ? busy_mask : 4'b0000;
      mem_err  = (c == err_at);
      if (scramble && c == 1) begin
        addr0 = ~addr0; addr1 = ~addr1; wr0 = ~wr0; wr1 = ~wr1;
      end
      if (c == drop_at) req0 = 1'b0;
      if (grant0 && first_g0 < 0) first_g0 = cyc;
      if (grant1 && first_g1 < 0) first_g1 = cyc;
      if (done0) req0 = 1'b0;
      if (done1) req1 = 1'b0;
      if (!req0 && !req1 && done_q.size() == 0 && !done0 && !done1) begin
        timed_out = 1'b0;
        break;
      end
    end
    mem_busy = 4'b0000;
    mem_err  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks = checks + 1;
    if (outs !== 62'd0) begin
      errors = errors + 1;
      $display("FAIL reset_outputs got %h required 0", outs);
    end
    checks = checks + 1;
    if (grant0 !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL reset_no_grant got grant0=%0b required 0", grant0);
    end
    req0 = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks = checks + 1;
    if (outs !== 62'd0) begin
      errors = errors + 1;
      $display("FAIL idle_outputs got %h required 0", outs);
    end
  endtask

  task automatic test_write_single();
    int t0, g0, g1;
    bit to;
    wr1 = 1'b1; addr1 = 13'h0041; req1 = 1'b1;
    t0 = cyc;
    push_txn(1'b1, 1'b1, 13'h0041, t0, 4, 0, 1'b0);
    run_txns(t0, -100, 0, 4'b0000, -100, 1'b0, -100, g0, g1, to);
    checks = checks + 1;
    if (to) begin errors = errors + 1; $display("FAIL write_timeout got timeout required completion"); end
    checks = checks + 1;
    if (g0 !== -1) begin errors = errors + 1; $display("FAIL write_grant0 got first grant0 at %0d required never", g0); end
    checks = checks + 1;
    if (g1 !== t0 + 1) begin errors = errors + 1; $display("FAIL write_grant1 got %0d required %0d", g1, t0 + 1); end
  endtask

  task automatic test_read_single();
    int t0, g0, g1;
    bit to;
    wr0 = 1'b0; addr0 = 13'h0000; req0 = 1'b1;
    t0 = cyc;
    push_txn(1'b0, 1'b0, 13'h0000, t0, 4, 0, 1'b0);
    // Address and direction are scrambled after grant; the latched values must be used.
    run_txns(t0, -100, 0, 4'b0000, -100, 1'b1, -100, g0, g1, to);
    checks = checks + 1;
    if (to) begin errors = errors + 1; $display("FAIL read_timeout got timeout required completion"); end
    checks = checks + 1;
    if (g0 !== t0 + 1 || g1 !== -1) begin
      errors = errors + 1;
      $display("FAIL read_grant got g0=%0d g1=%0d required g0=%0d g1=-1", g0, g1, t0 + 1);
    end
  endtask

  task automatic test_round_robin();
    int t0, t2, g0, g1;
    bit to;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    wr0 = 1'b0; addr0 = 13'h0010; req0 = 1'b1;
    wr1 = 1'b1; addr1 = 13'h0022; req1 = 1'b1;
    t0 = cyc;
    push_txn(1'b0, 1'b0, 13'h0010, t0, 4, 0, 1'b0);
    // Requester 1 waits: seen in IDLE the cycle after done0 (t0+8), granted next.
    push_txn(1'b1, 1'b1, 13'h0022, t0 + 9, 4, 0, 1'b0);
    run_txns(t0, -100, 0, 4'b0000, -100, 1'b0, -100, g0, g1, to);
    checks = checks + 1;
    if (to) begin errors = errors + 1; $display("FAIL rr1_timeout got timeout required completion"); end
    checks = checks + 1;
    if (g0 !== t0 + 1 || g1 !== t0 + 10) begin
      errors = errors + 1;
      $display("FAIL rr1_order got g0=%0d g1=%0d required g0=%0d g1=%0d", g0, g1, t0 + 1, t0 + 10);
    end
    wr0 = 1'b0; addr0 = 13'h0033; req0 = 1'b1;
    wr1 = 1'b1; addr1 = 13'h0044; req1 = 1'b1;
    t2 = cyc;
    push_txn(1'b1, 1'b1, 13'h0044, t2, 4, 0, 1'b0);
    push_txn(1'b0, 1'b0, 13'h0033, t2 + 6, 4, 0, 1'b0);
    run_txns(t2, -100, 0, 4'b0000, -100, 1'b0, -100, g0, g1, to);
    checks = checks + 1;
    if (to) begin errors = errors + 1; $display("FAIL rr2_timeout got timeout required completion"); end
    checks = checks + 1;
    if (g1 !== t2 + 1 || g0 !== t2 + 7) begin
      errors = errors + 1;
      $display("FAIL rr2_order got g0=%0d g1=%0d required g0=%0d g1=%0d", g0, g1, t2 + 7, t2 + 1);
    end
  endtask

  task automatic test_busy_hold();
    int t0, g0, g1;
    bit to;
    wr0 = 1'b1; addr0 = 13'h0003; req0 = 1'b1;
    t0 = cyc;
    // Bank 2 busy during cycles 3..5: beat 2 slips to cycle 6, done to cycle 8.
    push_txn(1'b0, 1'b1, 13'h0003, t0, 2, 3, 1'b0);
    run_txns(t0, 3, 3, 4'b0100, -100, 1'b0, -100, g0, g1, to);
    checks = checks + 1;
    if (to) begin errors = errors + 1; $display("FAIL busy_timeout got timeout required completion"); end
    checks = checks + 1;
    if (g0 !== t0 + 1) begin errors = errors + 1; $display("FAIL busy_grant got %0d required %0d", g0, t0 + 1); end
  endtask

  task automatic test_mem_err();
    int t0, g0, g1;
    bit to;
    wr0 = 1'b0; addr0 = 13'h0005; req0 = 1'b1;
    t0 = cyc;
    push_txn(1'b0, 1'b0, 13'h0005, t0, 4, 0, 1'b1);
    // Error pulsed while beat 1 issues; owner also drops req early, which must be ignored.
    run_txns(t0, -100, 0, 4'b0000, 2, 1'b1, 2, g0, g1, to);
    checks = checks + 1;
    if (to) begin errors = errors + 1; $display("FAIL err_timeout got timeout required completion"); end
  endtask

  task automatic test_reset_mid();
    int t0, g0, g1;
    bit to;
    wr0 = 1'b0; addr0 = 13'h0007; req0 = 1'b1;
    t0 = cyc;
    push_txn(1'b0, 1'b0, 13'h0007, t0, 4, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    req0  = 1'b0;
    #1;
    checks = checks + 1;
    if (outs !== 62'd0) begin
      errors = errors + 1;
      $display("FAIL midreset_outputs got %h required 0", outs);
    end
    strobe_q.delete();
    rv_q.delete();
    done_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    wr0 = 1'b0; addr0 = 13'h0009; req0 = 1'b1;
    t0 = cyc;
    push_txn(1'b0, 1'b0, 13'h0009, t0, 4, 0, 1'b0);
    run_txns(t0, -100, 0, 4'b0000, -100, 1'b0, -100, g0, g1, to);
    checks = checks + 1;
    if (to || g0 !== t0 + 1) begin
      errors = errors + 1;
      $display("FAIL post_reset_txn got timeout=%0b g0=%0d required timeout=0 g0=%0d", to, g0, t0 + 1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
    addr0 = 13'd0; addr1 = 13'd0;
    mem_busy = 4'b0000; mem_err = 1'b0;
    test_reset();
    test_write_single();
    test_read_single();
    test_round_robin();
    test_busy_hold();
    test_mem_err();
    test_reset_mid();
    checks = checks + 1;
    if (strobe_q.size() != 0 || rv_q.size() != 0 || done_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL scoreboard_drain got strobes=%0d rvalids=%0d dones=%0d left required 0",
               strobe_q.size(), rv_q.size(), done_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single four-bank main memory between the instruction-cache controller (requester 0) and the data-cache controller (requester 1).
- A granted requester owns the memory for one full 4-word line transaction, either a line fill or a writeback.
- The block sequences the per-bank beats, holds a beat while its target bank reports busy, and steers read data back to the owner.
- It sits between the two cache controllers and the memory.

Parameters:
- DATA_W, 16: memory word width.
- RD_LAT, 2: cycles from a read beat being issued to valid mem_rdata; must be 1 or more.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0, req1  in  1  line transaction request; held until the matching done.
- wr0, wr1  in  1  1 = writeback, 0 = fill; sampled at grant.
- addr0, addr1  in  13  line address (byte address [15:3]); sampled at grant.
- wdata0, wdata1  in  DATA_W  write word for the beat given by beat.
- grant0, grant1  out  1  high for the whole ownership; one-hot or zero.
- beat  out  2  word index of the beat currently presented.
- rvalid0, rvalid1  out  1  rdata valid for the owner.
- rbeat  out  2  word index of rdata.
- rdata  out  DATA_W  registered copy of mem_rdata.
- done0, done1  out  1  one-cycle completion pulse.
- err0, err1  out  1  valid only with done; 1 = mem_err occurred during the transaction.
- mem_addr  out  16  {line_addr, beat, 1'b0}.
- mem_wr, mem_rd  out  1  beat strobes, at most one high.
- mem_wdata  out  DATA_W  wdata of the owner.
- mem_rdata  in  DATA_W  memory read data.
- mem_busy  in  4  per-bank busy, combinational this cycle.
- mem_err  in  1  memory error.

Behaviour:
- Reset: state IDLE, rr_ptr = 0, beat = 0, read pipeline cleared. Every output is 0, including mem_addr and rdata. Reset mid-transaction aborts it with no done.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - With no request, stay in IDLE.
  - With one request, grant that requester.
  - With both requesting, grant rr_ptr's requester, then set rr_ptr to the other side.
  - On grant, latch owner, wr and addr. Go to ISSUE with beat = 0. grant_x rises the next cycle.
- ISSUE:
  - Target bank = beat (mem_addr[2:1]).
  - If mem_busy[beat] = 1: mem_rd = mem_wr = 0, and beat holds.
  - Otherwise assert mem_wr or mem_rd for one cycle and push {rd, beat} into the RD_LAT-deep pipeline.
  - After beat 3 is issued: a write goes to DONE; a read goes to DRAIN.
- DRAIN: wait until the pipeline is empty, then go to DONE.
- Read data:
  - A pipeline entry exits RD_LAT cycles after issue.
  - On exit, rdata <= mem_rdata and rbeat <= entry beat; rvalid_owner pulses the following cycle.
  - Busy holds create gaps, but rbeat order stays 0..3.
- DONE:
  - done_owner = 1 for one cycle; err_owner = sticky error flag. The flag is set by mem_err on any cycle in ISSUE or DRAIN.
  - grant drops and state returns to IDLE.
  - A new grant is issued no earlier than the cycle after returning to IDLE, so there is one idle cycle between owners.
- Timing, no busy, request seen at cycle 0:
  - Write: beats issued cycles 1-4; done at cycle 5.
  - Read: beats issued cycles 1-4, rvalid cycles 4-7 (beat n issued at cycle n+1, rvalid at cycle n+4), done at cycle 8. DONE follows DRAIN, and the last rvalid lands in DRAIN's final cycle.
- Request handling during a transaction:
  - The owner dropping req mid-transaction is ignored; the transaction completes.
  - A request from the non-owner waits.
  - wr and addr changes after grant are ignored.
- Starvation: under continuous dual requests, round-robin alternates strictly.
- mem_err does not abort a transaction; all beats still complete.

Decomposition:
- Shared package:
  - state encodings: IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, DONE = 2'd3;
  - NUM_BANKS = 4 and BEATS = 4;
  - requester IDs: REQ_I = 0, REQ_D = 1.
- One sub-module, rd_track_pipe: an RD_LAT-deep shift register of {valid, beat} with an empty flag.

Test Plan:
- req1 alone, wr1 = 1, addr1 = 13'h0041:
  - mem_wr on cycles 1-4 with mem_addr 0x0208, 0x020A, 0x020C, 0x020E;
  - done1 at cycle 5, err1 = 0, grant0 never high.
- req0 alone read, addr0 = 0, memory returns 0xA0+n:
  - rvalid0 on cycles 4-7 with rbeat 0-3 and rdata 0xA0-0xA3;
  - done0 at cycle 8.
- req0 and req1 rise together after reset:
  - requester 0 is granted first;
  - requester 1 is granted on the cycle after done0;
  - the next simultaneous pair is granted to requester 1 first.
- Write with mem_busy = 4'b0100 held for 3 cycles starting at beat 2:
  - beat 2 is held for 3 cycles with no strobe;
  - done is delayed exactly 3 cycles to cycle 8.
- Read with mem_err pulsed during beat 1 → all 4 rvalid still occur, done0 = 1 and err0 = 1.
- rst_n low at cycle 3 of a read → all outputs 0 immediately; after release, a fresh req0 is granted normally.
